// File: rtl/floor_request_scheduler_pkg.sv
// Shared elevator definitions: default geometry and the scheduler/controller state encoding.
package elevator_pkg;

  localparam int DEFAULT_NUM_FLOORS = 16;
  localparam int DEFAULT_FLOOR_W    = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    TRAVEL = 2'd3
  } state_e;

endpackage

// File: rtl/floor_request_scheduler_if.sv
// Call inputs, car feedback and the target valid/ready handshake between the scheduler and the controller side.
interface floor_request_scheduler_if #(
  parameter int NUM_FLOORS = elevator_pkg::DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::DEFAULT_FLOOR_W
);

  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  arrived;
  logic                  target_ready;
  logic [FLOOR_W-1:0]    target_floor;
  logic                  target_valid;
  logic                  dir_up;
  logic [NUM_FLOORS-1:0] pending;
  logic                  busy;

  // Controller / call-panel side.
  modport master (
    output call_req, current_floor, arrived, target_ready,
    input  target_floor, target_valid, dir_up, pending, busy
  );

  // Scheduler side.
  modport slave (
    input  call_req, current_floor, arrived, target_ready,
    output target_floor, target_valid, dir_up, pending, busy
  );

endinterface

// File: rtl/floor_request_scheduler_scan_picker.sv
// Combinational SCAN pick: nearest pending floor ahead of the car, else reverse to the nearest one behind.
module scan_picker #(
  parameter int NUM_FLOORS = 16,
  parameter int FLOOR_W    = 5
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  dir_up,
  output logic [FLOOR_W-1:0]    pick_floor,
  output logic                  pick_dir_up,
  output logic                  pick_found
);

  logic [NUM_FLOORS-1:0] above_bits;
  logic [NUM_FLOORS-1:0] below_bits;
  logic [FLOOR_W-1:0]    lowest_above;
  logic [FLOOR_W-1:0]    highest_below;

  // The floor the car stands on counts as "ahead" in either direction, so it never flips dir_up.
  always_comb begin
    int f;
    f          = int'(current_floor);
    above_bits = '0;
    below_bits = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_bits[i] = pending[i] & (dir_up ? (i >= f) : (i > f));
      below_bits[i] = pending[i] & (dir_up ? (i < f) : (i <= f));
    end
  end

  always_comb begin
    lowest_above = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (above_bits[i]) lowest_above = FLOOR_W'(i);
    end
  end

  always_comb begin
    highest_below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (below_bits[i]) highest_below = FLOOR_W'(i);
    end
  end

  always_comb begin
    pick_found = |(above_bits | below_bits);
    if (dir_up) begin
      pick_dir_up = |above_bits;
      pick_floor  = (|above_bits) ? lowest_above : highest_below;
    end else begin
      pick_dir_up = ~(|below_bits);
      pick_floor  = (|below_bits) ? highest_below : lowest_above;
    end
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// Pending-call bitmap plus IDLE/SELECT/ISSUE/TRAVEL FSM handing one SCAN-ordered target at a time to the controller.
module floor_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W    = DEFAULT_FLOOR_W
) (
  input logic                     clk,
  input logic                     reset,
  floor_request_scheduler_if.slave bus
);

  state_e                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  dir_up_q, dir_up_d;

  logic [FLOOR_W-1:0]    pick_floor;
  logic                  pick_dir_up;
  logic                  pick_found;
  logic                  floor_ok;
  logic                  commit_pick;

  scan_picker #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_picker (
    .pending       (pending_q),
    .current_floor (bus.current_floor),
    .dir_up        (dir_up_q),
    .pick_floor    (pick_floor),
    .pick_dir_up   (pick_dir_up),
    .pick_found    (pick_found)
  );

  // An out-of-range car position parks the FSM in SELECT until the controller reports a real floor.
  assign floor_ok    = int'(bus.current_floor) < NUM_FLOORS;
  assign commit_pick = (state_q == SELECT) && floor_ok && pick_found;

  // New calls accumulate every cycle; on arrival the target bit is cleared last so the open door absorbs a same-floor call.
  always_comb begin
    pending_d = pending_q | bus.call_req;
    if ((state_q == TRAVEL) && bus.arrived) begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (int'(target_q) == i) pending_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    target_d = target_q;
    dir_up_d = dir_up_q;
    if (commit_pick) begin
      target_d = pick_floor;
      dir_up_d = pick_dir_up;
    end
  end

  // NOTE: the pending bitmap is plain flops rather than a memory, so it is fully reset and a reset drops every call.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      target_q  <= '0;
      dir_up_q  <= 1'b1;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
      dir_up_q  <= dir_up_d;
    end
  end

  // NOTE: state uses non-blocking assignment so every flop samples pre-edge values regardless of process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d defaults to state_q before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (|pending_q) state_d = SELECT;
      SELECT: if (commit_pick) state_d = ISSUE;
      ISSUE:  if (bus.target_ready) state_d = TRAVEL;
      TRAVEL: if (bus.arrived) state_d = (|pending_d) ? SELECT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.target_valid = (state_q == ISSUE);
    bus.busy         = (state_q != IDLE);
    bus.target_floor = target_q;
    bus.dir_up       = dir_up_q;
    bus.pending      = pending_q;
  end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench: reset, single call, SCAN order, backpressure, same-floor call, arrival collision, range hold.
module tb_floor_request_scheduler;

  localparam int NF = 16;
  localparam int FW = 5;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  floor_request_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) ifc ();

  floor_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept();
    ifc.target_ready = 1'b1;
    tick();
    ifc.target_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ifc.call_req      = '0;
    ifc.current_floor = '0;
    ifc.arrived       = 1'b0;
    ifc.target_ready  = 1'b0;
    tick();
    tick();
    check("rst_valid",   ifc.target_valid, 0);
    check("rst_busy",    ifc.busy, 0);
    check("rst_pending", ifc.pending, 0);
    check("rst_dir",     ifc.dir_up, 1);
    check("rst_target",  ifc.target_floor, 0);
    reset = 1'b0;
    tick();

    // Single call at floor 12 from floor 0.
    ifc.call_req = 16'h1000;
    tick();
    ifc.call_req = '0;
    check("single_pend_n",   ifc.pending, 16'h1000);
    check("single_busy_n",   ifc.busy, 0);
    tick();
    check("single_busy_sel", ifc.busy, 1);
    check("single_valid_sel", ifc.target_valid, 0);
    tick();
    check("single_valid",  ifc.target_valid, 1);
    check("single_target", ifc.target_floor, 12);
    check("single_dir",    ifc.dir_up, 1);
    accept();
    check("single_valid_drop", ifc.target_valid, 0);
    tick();
    check("single_travel_busy", ifc.busy, 1);
    ifc.arrived = 1'b1;
    tick();
    ifc.arrived = 1'b0;
    check("single_clear", ifc.pending, 0);
    check("single_idle",  ifc.busy, 0);

    // SCAN order from floor 5 going up with calls 3, 8, 13.
    ifc.current_floor = 5;
    ifc.call_req = 16'h2108;
    tick();
    ifc.call_req = '0;
    tick();
    tick();
    check("scan1_target", ifc.target_floor, 8);
    check("scan1_dir",    ifc.dir_up, 1);
    accept();
    ifc.current_floor = 8;
    ifc.arrived = 1'b1;
    tick();
    ifc.arrived = 1'b0;
    check("scan1_pend", ifc.pending, 16'h2008);
    check("scan1_busy", ifc.busy, 1);
    tick();
    check("scan2_target", ifc.target_floor, 13);
    check("scan2_dir",    ifc.dir_up, 1);
    accept();
    ifc.current_floor = 13;
    ifc.arrived = 1'b1;
    tick();
    ifc.arrived = 1'b0;
    tick();
    check("scan3_target", ifc.target_floor, 3);
    check("scan3_dir",    ifc.dir_up, 0);
    check("scan3_valid",  ifc.target_valid, 1);
    accept();
    ifc.current_floor = 3;
    ifc.arrived = 1'b1;
    tick();
    ifc.arrived = 1'b0;
    check("scan_done_pend", ifc.pending, 0);
    check("scan_done_busy", ifc.busy, 0);

    // Same-floor call at 7 while heading down keeps the direction.
    ifc.current_floor = 7;
    ifc.call_req = 16'h0080;
    tick();
    ifc.call_req = '0;
    tick();
    tick();
    check("same_target", ifc.target_floor, 7);
    check("same_dir",    ifc.dir_up, 0);

    // Backpressure: 20 cycles without ready, call 2 arrives mid-way.
    for (int c = 0; c < 20; c++) begin
      ifc.call_req = (c == 5) ? 16'h0004 : 16'h0000;
      tick();
      check("bp_valid",  ifc.target_valid, 1);
      check("bp_target", ifc.target_floor, 7);
    end
    ifc.call_req = '0;
    check("bp_pend", ifc.pending, 16'h0084);
    accept();
    check("bp_travel_valid", ifc.target_valid, 0);

    // Collision: arrival at 7 with calls 7 and 4 in the same cycle.
    ifc.arrived  = 1'b1;
    ifc.call_req = 16'h0090;
    tick();
    ifc.arrived  = 1'b0;
    ifc.call_req = '0;
    check("coll_pend", ifc.pending, 16'h0014);
    check("coll_busy", ifc.busy, 1);
    check("coll_valid_sel", ifc.target_valid, 0);
    tick();
    check("coll_target", ifc.target_floor, 4);
    check("coll_dir",    ifc.dir_up, 0);

    // Arrival pulse while in ISSUE is ignored.
    ifc.arrived = 1'b1;
    tick();
    ifc.arrived = 1'b0;
    check("ign_pend",  ifc.pending, 16'h0014);
    check("ign_valid", ifc.target_valid, 1);

    // Asynchronous reset mid-cycle while a target is offered.
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid",  ifc.target_valid, 0);
    check("arst_busy",   ifc.busy, 0);
    check("arst_pend",   ifc.pending, 0);
    check("arst_dir",    ifc.dir_up, 1);
    check("arst_target", ifc.target_floor, 0);
    tick();
    reset = 1'b0;
    tick();

    // Out-of-range car position holds SELECT until it returns in range.
    ifc.current_floor = 20;
    ifc.call_req = 16'h0002;
    tick();
    ifc.call_req = '0;
    tick();
    tick();
    tick();
    check("range_hold_valid", ifc.target_valid, 0);
    check("range_hold_busy",  ifc.busy, 1);
    ifc.current_floor = 0;
    tick();
    check("range_valid",  ifc.target_valid, 1);
    check("range_target", ifc.target_floor, 1);
    check("range_dir",    ifc.dir_up, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
